rsa_modmul_arbiter: RTL
=======================

// Module: rsa_modmul_arbiter
// PURPOSE
//  Shares one rsa_mult + rsa_div pair (one modular-multiply engine) between two requesters,
//  typically the encrypt and decrypt exponentiation controllers. Each request computes
//  (a*b) mod m. Arbitration is round-robin, the engine sequence is mult then div, and the
//  result returns with a one-cycle valid pulse.
// PARAMETERS
//  WIDTH    128  operand, modulus and result width; product/dividend width is 2*WIDTH
//  TIMEOUT  512  max cycles spent in either wait state before the op is aborted with err
// PORTS
//  clk        in   1        clock, rising edge
//  reset_n    in   1        asynchronous, active-low reset
//  req        in   2        request per requester; hold high until own res_valid
//  a0,b0,m0   in   WIDTH    requester 0 operands and modulus; stable while req[0] is high
//  a1,b1,m1   in   WIDTH    requester 1 operands and modulus
//  gnt        out  2        one-hot; high from grant through DONE for the served requester
//  res_valid  out  2        one-cycle pulse to the served requester
//  result     out  WIDTH    (a*b) mod m; held until the next DONE
//  err        out  2        pulses with res_valid on modulus==0 or timeout
//  busy       out  1        high in any state except IDLE
//  mult_rst   out  1        one-cycle start pulse to rsa_mult
//  mult_a/b   out  WIDTH    multiplier operands
//  mult_done  in   1        multiplier finished
//  prod       in   2*WIDTH  multiplier product
//  div_rst_n  out  1        rsa_div start; low for one cycle starts a divide
//  div_a      out  2*WIDTH  dividend (full product, never truncated)
//  div_b      out  WIDTH    divisor (latched modulus)
//  remainder  in   WIDTH    divider remainder
//  div_done   in   1        divider finished
// BEHAVIOUR
//  Reset values: gnt=0, res_valid=0, result=0, err=0, busy=0, mult_rst=0, mult_a/b=0,
//   div_rst_n=1, div_a/b=0, state=IDLE, rr_ptr=0 (requester 0 has priority).
//  FSM: IDLE -> MUL_START -> MUL_WAIT -> DIV_START -> DIV_WAIT -> DONE -> IDLE.
//  IDLE: if req!=0, pick winner: sole requester, else rr_ptr (both high). Latch a,b,m of the
//   winner and set gnt. If the latched m==0, go to DONE with result=0 and err; else MUL_START.
//  MUL_START: mult_rst=1 for exactly 1 cycle with mult_a/b driven; timeout counter cleared.
//  MUL_WAIT: mult_rst=0. mult_done is ignored in the first cycle (stale done). On a later
//   mult_done, latch prod into div_a and go to DIV_START.
//  DIV_START: div_rst_n=0 for exactly 1 cycle, div_b=m.
//  DIV_WAIT: div_rst_n=1. div_done is ignored in the first cycle. On a later div_done,
//   result<=remainder, go to DONE.
//  Timeout: the counter runs in both WAIT states. When it reaches TIMEOUT: result=0, err set,
//   go to DONE.
//  DONE (1 cycle): res_valid[g]=1, err[g] as computed, rr_ptr<=~g; next cycle gnt=0,
//   state=IDLE.
//  Latency (no timeout): grant cycle + 1 + Tmul + 1 + Tdiv + 1 done cycle; at least 1 idle
//   cycle between back-to-back ops.
//  A requester that drops req mid-op does not abort; the op completes and res_valid still
//   pulses. A req high in DONE is not arbitrated until IDLE.
//  Both req high continuously: grants strictly alternate 0,1,0,1.
//  Reset asserted mid-op: all outputs return to reset values immediately. Engines are left
//   to finish; their done is discarded because the FSM is in IDLE.
//  Operand inputs are don't-care after grant; only latched copies are used.
// STRUCTURE
//  Shared package rsa_pkg: WIDTH default, FSM state encoding (3 bits), TIMEOUT default,
//   requester index constants REQ_ENC=0, REQ_DEC=1.
//  One sub-module: rsa_rr_arb2 (2-way round-robin picker: req, rr_ptr -> one-hot win).
//  Everything else inline: FSM, operand latches, timeout counter.
// TESTING
//  1 req0 a=5 b=7 m=11 -> res_valid[0] pulse, result=2, err=0, gnt[1] never high.
//  2 req0 and req1 set on the same cycle after reset (a1=3 b1=4 m1=5) -> req0 served first;
//    then result=2 for req1; gnts alternate over 6 back-to-back ops.
//  3 req1 a=2^127 b=2 m=2^127-1 -> div_a=2^128 (no truncation), result=2.
//  4 req0 m=0 -> no mult_rst/div_rst_n pulse, result=0, err[0]=1 with res_valid[0].
//  5 mult_done model tied low -> after TIMEOUT cycles err[0]=1, result=0, back to IDLE,
//    next request served.
//  6 reset_n low in DIV_WAIT, then release -> all outputs at reset values; a late div_done is
//    ignored; a fresh req0 a=5 b=7 m=11 gives 2.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-multiply arbiter slice.
package rsa_pkg;

   localparam int RSA_WIDTH   = 128;
   localparam int RSA_TIMEOUT = 512;

   // Requester indices: encrypt controller on 0, decrypt controller on 1.
   localparam int REQ_ENC = 0;
   localparam int REQ_DEC = 1;

   // FSM state encoding (3 bits, legacy-compatible constants).
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_MUL_START = 3'd1;
   localparam logic [2:0] ST_MUL_WAIT  = 3'd2;
   localparam logic [2:0] ST_DIV_START = 3'd3;
   localparam logic [2:0] ST_DIV_WAIT  = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;

endpackage

// File: rtl/rsa_modmul_arbiter_if.sv
// Requester-side bus of the modmul arbiter: requests, operands, grants and results.
interface rsa_modmul_arbiter_if import rsa_pkg::*; #(
   parameter int WIDTH = RSA_WIDTH
);
   logic [1:0]       req;
   logic [WIDTH-1:0] a0, b0, m0;
   logic [WIDTH-1:0] a1, b1, m1;
   logic [1:0]       gnt;
   logic [1:0]       res_valid;
   logic [WIDTH-1:0] result;
   logic [1:0]       err;

   // Requesters drive requests and operands.
   modport master (
      output req, a0, b0, m0, a1, b1, m1,
      input  gnt, res_valid, result, err
   );

   // The arbiter consumes requests and returns grants and results.
   modport slave (
      input  req, a0, b0, m0, a1, b1, m1,
      output gnt, res_valid, result, err
   );
endinterface

// File: rtl/rsa_rr_arb2.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to rr_ptr.
module rsa_rr_arb2 import rsa_pkg::*; (
   input  logic [1:0] req,
   input  logic       rr_ptr,
   output logic [1:0] win
);

   // Combinational one-hot winner selection.
   always_comb begin
      win = '0;
      case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = rr_ptr ? 2'b10 : 2'b01;
         default: win = '0;
      endcase
   end

endmodule

// File: rtl/rsa_modmul_arbiter.sv
// Shares one multiply + divide engine pair between two requesters computing (a*b) mod m.
module rsa_modmul_arbiter import rsa_pkg::*; #(
   parameter int WIDTH   = RSA_WIDTH,
   parameter int TIMEOUT = RSA_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 reset_n,
   rsa_modmul_arbiter_if.slave  bus,
   output logic                 busy,
   output logic                 mult_rst,
   output logic [WIDTH-1:0]     mult_a,
   output logic [WIDTH-1:0]     mult_b,
   input  logic                 mult_done,
   input  logic [2*WIDTH-1:0]   prod,
   output logic                 div_rst_n,
   output logic [2*WIDTH-1:0]   div_a,
   output logic [WIDTH-1:0]     div_b,
   input  logic [WIDTH-1:0]     remainder,
   input  logic                 div_done
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [2:0]         state;
   logic               rr_ptr;
   logic [1:0]         win;
   logic [1:0]         gnt_q;
   logic [WIDTH-1:0]   a_q, b_q, m_q, result_q;
   logic [WIDTH-1:0]   a_sel, b_sel, m_sel;
   logic [2*WIDTH-1:0] prod_q;
   logic               err_q;
   logic [CW-1:0]      cnt;

   rsa_rr_arb2 u_arb (
      .req    (bus.req),
      .rr_ptr (rr_ptr),
      .win    (win)
   );

   // Operand mux for the current winner.
   always_comb begin
      a_sel = bus.a0;
      b_sel = bus.b0;
      m_sel = bus.m0;
      if (win[REQ_DEC]) begin
         a_sel = bus.a1;
         b_sel = bus.b1;
         m_sel = bus.m1;
      end
   end

   // Main FSM: grant, multiply, divide, report; timeout counter shared by both waits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         rr_ptr   <= 1'b0;
         gnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         prod_q   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         cnt      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win != 2'b00) begin
                  gnt_q <= win;
                  a_q   <= a_sel;
                  b_q   <= b_sel;
                  m_q   <= m_sel;
                  cnt   <= '0;
                  if (m_sel == '0) begin
                     result_q <= '0;
                     err_q    <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     err_q <= 1'b0;
                     state <= ST_MUL_START;
                  end
               end
            end
            ST_MUL_START: begin
               cnt   <= '0;
               state <= ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
               // cnt==0 marks the first wait cycle, where a done from the previous op may linger.
               if (cnt != '0 && mult_done) begin
                  prod_q <= prod;
                  state  <= ST_DIV_START;
               end else if (cnt == CW'(TIMEOUT)) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DIV_START: begin
               cnt   <= '0;
               state <= ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
               if (cnt != '0 && div_done) begin
                  result_q <= remainder;
                  state    <= ST_DONE;
               end else if (cnt == CW'(TIMEOUT)) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DONE: begin
               rr_ptr <= ~gnt_q[REQ_DEC];
               gnt_q  <= '0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Engine strobes and status decoded from state so reset clears them immediately.
   always_comb begin
      busy          = (state != ST_IDLE);
      mult_rst      = (state == ST_MUL_START);
      div_rst_n     = (state != ST_DIV_START);
      bus.res_valid = (state == ST_DONE) ? gnt_q : 2'b00;
      bus.err       = (state == ST_DONE && err_q) ? gnt_q : 2'b00;
   end

   assign bus.gnt    = gnt_q;
   assign bus.result = result_q;
   assign mult_a     = a_q;
   assign mult_b     = b_q;
   assign div_a      = prod_q;
   assign div_b      = m_q;

endmodule
